// File: rtl/alarm_cmp.sv
// alarm_cmp: multi-slot alarm comparator.
//
// Holds NCH alarm slots (programmed hour/minute plus an on/off state) and compares each
// slot's target against the live time of day on every mclk. A slot fires once per matching
// minute, goes pending, and the lowest-index pending slot is presented on ring/ring_idx until
// it is acknowledged, snoozed, rewritten or auto-cleared after RING_CYC unacknowledged cycles.
//
// Build option: define ALARM_SNOOZE_EN to enable snooze (SNOOZED state and the now+SNOOZE_MIN
// adder). Without it the snooze input is ignored and targets always equal programmed times.
//
// Ports:
//   mclk, rst_n          clock (rising edge) and asynchronous active-low reset
//   nowH, nowM           current time of day, 0..23 / 0..59
//   wr_en, wr_idx        write strobe and slot index
//   wr_H, wr_M           alarm time to write (out-of-range writes are dropped)
//   wr_enable            1 arms the slot, 0 turns it off
//   ack, snooze          act on the slot currently shown on ring_idx
//   ring, ring_idx       any slot pending / lowest pending slot (0 when idle)
//   pending              per-slot pending mask
//   timeout              one-cycle pulse when a ring auto-clears
module alarm_cmp #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned RING_CYC   = 60000,
    parameter int unsigned SNOOZE_MIN = 5,
    localparam int unsigned IW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           mclk,
    input  logic           rst_n,
    input  logic [4:0]     nowH,
    input  logic [5:0]     nowM,
    input  logic           wr_en,
    input  logic [IW-1:0]  wr_idx,
    input  logic [4:0]     wr_H,
    input  logic [5:0]     wr_M,
    input  logic           wr_enable,
    input  logic           ack,
    input  logic           snooze,
    output logic           ring,
    output logic [IW-1:0]  ring_idx,
    output logic [NCH-1:0] pending,
    output logic           timeout
);

    localparam int unsigned TW = $clog2(RING_CYC);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {StOff, StArmed, StFired, StSnoozed} slot_st_e;
`else
    typedef enum logic [1:0] {StOff, StArmed, StFired} slot_st_e;
`endif

    slot_st_e       st_q    [NCH];
    slot_st_e       st_d    [NCH];
    logic [4:0]     prg_h_q [NCH];
    logic [4:0]     prg_h_d [NCH];
    logic [5:0]     prg_m_q [NCH];
    logic [5:0]     prg_m_d [NCH];
    logic [4:0]     tgt_h   [NCH];
    logic [5:0]     tgt_m   [NCH];
    logic [NCH-1:0] cmp_q, cmp_d, cmp_prev_q;
    logic [TW-1:0]  timer_q, timer_d, timer_eff;
    logic [IW-1:0]  idx_q;
    logic           timeout_q;
    logic           wr_ok, ack_eff, snz_eff, wr_ring, to_hit, restart;

`ifdef ALARM_SNOOZE_EN
    // Compare target is held apart from the programmed time so snooze never loses it.
    logic [4:0] tgt_h_q [NCH];
    logic [4:0] tgt_h_d [NCH];
    logic [5:0] tgt_m_q [NCH];
    logic [5:0] tgt_m_d [NCH];
    logic [6:0] snz_m_sum;
    logic [4:0] snz_h_sum;

    // now + SNOOZE_MIN with minute and hour wrap.
    always_comb begin
        snz_m_sum = {1'b0, nowM} + 7'(SNOOZE_MIN);
        snz_h_sum = nowH;
        if (snz_m_sum >= 7'd60) begin
            snz_m_sum = snz_m_sum - 7'd60;
            snz_h_sum = nowH + 5'd1;
        end
        if (snz_h_sum >= 5'd24) begin
            snz_h_sum = snz_h_sum - 5'd24;
        end
    end

    assign snz_eff = snooze & ring & ~ack;
`else
    logic unused_snooze;
    assign unused_snooze = snooze;
    assign snz_eff       = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
`ifdef ALARM_SNOOZE_EN
            tgt_h[i] = tgt_h_q[i];
            tgt_m[i] = tgt_m_q[i];
`else
            tgt_h[i] = prg_h_q[i];
            tgt_m[i] = prg_m_q[i];
`endif
        end
    end

    // Downward scan leaves the lowest pending index in ring_idx.
    always_comb begin
        pending  = '0;
        ring_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (st_q[i] == StFired) begin
                pending[i] = 1'b1;
                ring_idx   = IW'(i);
            end
        end
    end

    assign ring    = |pending;
    assign timeout = timeout_q;

    assign wr_ok   = wr_en && (wr_H <= 5'd23) && (wr_M <= 6'd59) && (32'(wr_idx) < NCH);
    assign ack_eff = ack & ring;
    assign wr_ring = wr_ok & ring & (wr_idx == ring_idx);

    // A change of the shown slot restarts the ring timer.
    assign timer_eff = (ring_idx == idx_q) ? timer_q : '0;
    assign to_hit    = ring & ~ack_eff & ~snz_eff & ~wr_ring & (timer_eff == TW'(RING_CYC - 1));
    assign restart   = ack_eff | snz_eff | wr_ring | to_hit;
    assign timer_d   = (!ring || restart) ? '0 : timer_eff + TW'(1);

    // Per-slot next state; priority write > ack > snooze > timeout > fire.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            st_d[i]    = st_q[i];
            prg_h_d[i] = prg_h_q[i];
            prg_m_d[i] = prg_m_q[i];
`ifdef ALARM_SNOOZE_EN
            tgt_h_d[i] = tgt_h_q[i];
            tgt_m_d[i] = tgt_m_q[i];
`endif
            cmp_d[i] = (nowH == tgt_h[i]) && (nowM == tgt_m[i]) &&
                       (nowH <= 5'd23) && (nowM <= 6'd59);
            if (wr_ok && (wr_idx == IW'(i))) begin
                prg_h_d[i] = wr_H;
                prg_m_d[i] = wr_M;
`ifdef ALARM_SNOOZE_EN
                tgt_h_d[i] = wr_H;
                tgt_m_d[i] = wr_M;
`endif
                st_d[i]    = wr_enable ? StArmed : StOff;
                cmp_d[i]   = 1'b0;  // a fresh target must see its own rising match
            end else if (ring && (ring_idx == IW'(i)) && (ack_eff || to_hit)) begin
                st_d[i] = StArmed;
`ifdef ALARM_SNOOZE_EN
                tgt_h_d[i] = prg_h_q[i];
                tgt_m_d[i] = prg_m_q[i];
            end else if (ring && (ring_idx == IW'(i)) && snz_eff) begin
                st_d[i]    = StSnoozed;
                tgt_h_d[i] = snz_h_sum;
                tgt_m_d[i] = snz_m_sum[5:0];
            end else if (cmp_q[i] && !cmp_prev_q[i] &&
                         (st_q[i] == StArmed || st_q[i] == StSnoozed)) begin
                st_d[i] = StFired;
`else
            end else if (cmp_q[i] && !cmp_prev_q[i] && (st_q[i] == StArmed)) begin
                st_d[i] = StFired;
`endif
            end
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]    <= StOff;
                prg_h_q[i] <= '0;
                prg_m_q[i] <= '0;
`ifdef ALARM_SNOOZE_EN
                tgt_h_q[i] <= '0;
                tgt_m_q[i] <= '0;
`endif
            end
            cmp_q      <= '0;
            cmp_prev_q <= '0;
            timer_q    <= '0;
            idx_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]    <= st_d[i];
                prg_h_q[i] <= prg_h_d[i];
                prg_m_q[i] <= prg_m_d[i];
`ifdef ALARM_SNOOZE_EN
                tgt_h_q[i] <= tgt_h_d[i];
                tgt_m_q[i] <= tgt_m_d[i];
`endif
            end
            cmp_q      <= cmp_d;
            cmp_prev_q <= cmp_q;
            timer_q    <= timer_d;
            idx_q      <= ring_idx;
            timeout_q  <= to_hit;
        end
    end

endmodule

// File: tb/tb_alarm_cmp.sv
`timescale 1ns/1ps
module tb_alarm_cmp;
    localparam int NCH        = 4;
    localparam int IW         = 2;
    localparam int RING_CYC   = 10;
    localparam int SNOOZE_MIN = 5;
    localparam int M_OFF = 0, M_ARM = 1, M_FIRE = 2, M_SNZ = 3;

    logic           mclk = 1'b0;
    logic           rst_n = 1'b0;
    logic [4:0]     nowH = '0;
    logic [5:0]     nowM = '0;
    logic           wr_en = 1'b0;
    logic [IW-1:0]  wr_idx = '0;
    logic [4:0]     wr_H = '0;
    logic [5:0]     wr_M = '0;
    logic           wr_enable = 1'b0;
    logic           ack = 1'b0;
    logic           snooze = 1'b0;
    logic           ring;
    logic [IW-1:0]  ring_idx;
    logic [NCH-1:0] pending;
    logic           timeout;

    int errors = 0;
    int checks = 0;

    alarm_cmp #(.NCH(NCH), .RING_CYC(RING_CYC), .SNOOZE_MIN(SNOOZE_MIN)) dut (
        .mclk(mclk), .rst_n(rst_n), .nowH(nowH), .nowM(nowM),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_H(wr_H), .wr_M(wr_M), .wr_enable(wr_enable),
        .ack(ack), .snooze(snooze),
        .ring(ring), .ring_idx(ring_idx), .pending(pending), .timeout(timeout)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: times held as minute-of-day, slot states as small integers.
    int m_st  [NCH] = '{default: 0};
    int m_prg [NCH] = '{default: 0};
    int m_tgt [NCH] = '{default: 0};
    bit m_c1  [NCH] = '{default: 0};  // time matched on the previous edge
    bit m_c0  [NCH] = '{default: 0};  // time matched the edge before that
    int m_age = 0;
    int m_last_ri = 0;
    bit m_last_ring = 0;
    bit m_to = 0;

    function automatic logic [NCH-1:0] m_pend_f();
        logic [NCH-1:0] p = '0;
        for (int i = 0; i < NCH; i++) p[i] = (m_st[i] == M_FIRE);
        return p;
    endfunction

    function automatic int m_ri_f();
        int r = 0;
        for (int i = NCH - 1; i >= 0; i--) if (m_st[i] == M_FIRE) r = i;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_st[i] = M_OFF; m_prg[i] = 0; m_tgt[i] = 0; m_c1[i] = 0; m_c0[i] = 0;
        end
        m_age = 0; m_last_ri = 0; m_last_ring = 0; m_to = 0;
    endtask

    task automatic model_step();
        bit rg, now_ok, wr_hit, a, s, wr_ring, to, fire, nc1;
        int ri, age_eff, now_t, wt;
        rg = |m_pend_f();
        ri = m_ri_f();
        age_eff = (rg && m_last_ring && ri == m_last_ri) ? m_age : 0;
        now_ok = (nowH <= 23) && (nowM <= 59);
        now_t  = nowH * 60 + nowM;
        wr_hit = wr_en && (wr_H <= 23) && (wr_M <= 59) && (int'(wr_idx) < NCH);
        wt     = wr_H * 60 + wr_M;
        a      = ack && rg;
`ifdef ALARM_SNOOZE_EN
        s      = snooze && rg && !ack;
`else
        s      = 0;
`endif
        wr_ring = wr_hit && rg && (int'(wr_idx) == ri);
        to      = rg && !a && !s && !wr_ring && (age_eff == RING_CYC - 1);
        for (int i = 0; i < NCH; i++) begin
            fire = m_c1[i] && !m_c0[i];
            nc1  = now_ok && (now_t == m_tgt[i]);
            m_c0[i] = m_c1[i];
            m_c1[i] = nc1;
            if (wr_hit && int'(wr_idx) == i) begin
                m_prg[i] = wt; m_tgt[i] = wt;
                m_st[i]  = wr_enable ? M_ARM : M_OFF;
                m_c1[i]  = 0;
            end else if (rg && i == ri && (a || to)) begin
                m_st[i] = M_ARM; m_tgt[i] = m_prg[i];
            end else if (rg && i == ri && s) begin
                m_st[i] = M_SNZ; m_tgt[i] = (now_t + SNOOZE_MIN) % 1440;
            end else if (fire && (m_st[i] == M_ARM || m_st[i] == M_SNZ)) begin
                m_st[i] = M_FIRE;
            end
        end
        m_age = (!rg || a || s || to || wr_ring) ? 0 : age_eff + 1;
        m_last_ring = rg; m_last_ri = ri; m_to = to;
    endtask

    initial forever begin
        @(posedge mclk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    // Compare every cycle, half a period after the active edge.
    initial forever begin
        @(negedge mclk);
        if (rst_n) begin
            chk("pending", pending, m_pend_f());
            chk("ring", ring, |m_pend_f());
            chk("ring_idx", ring_idx, m_ri_f());
            chk("timeout", timeout, m_to);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge mclk);
    endtask

    task automatic set_now(input int h, input int m);
        nowH = 5'(h); nowM = 6'(m);
    endtask

    task automatic wr(input int idx, input int h, input int m, input bit en);
        wr_en = 1'b1; wr_idx = IW'(idx); wr_H = 5'(h); wr_M = 6'(m); wr_enable = en;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; cyc(); ack = 1'b0;
    endtask

    task automatic pulse_snz();
        snooze = 1'b1; cyc(); snooze = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cyc(2);
        chk("rst_ring", ring, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ring_idx", ring_idx, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;

        // Single slot fires two cycles after the time change, once per minute.
        set_now(7, 29); wr(1, 7, 30, 1); cyc(2);
        set_now(7, 30); cyc(1);
        chk("t1_not_yet", ring, 0);
        cyc(1);
        chk("t1_ring", ring, 1);
        chk("t1_idx", ring_idx, 1);
        chk("t1_pend", pending, 4'b0010);
        pulse_ack();
        chk("t1_ack_clear", ring, 0);
        cyc(1000);
        chk("t1_no_refire", pending, 0);

        // Two slots on the same minute, lowest shown first.
        set_now(11, 59); wr(0, 12, 0, 1); wr(2, 12, 0, 1); cyc(1);
        set_now(12, 0); cyc(2);
        chk("t2_pend", pending, 4'b0101);
        chk("t2_idx", ring_idx, 0);
        pulse_ack();
        chk("t2_idx_next", ring_idx, 2);
        chk("t2_ring_still", ring, 1);
        pulse_ack();
        chk("t2_ring_off", ring, 0);

        // Snooze across midnight.
        set_now(23, 57); wr(0, 23, 58, 1); cyc(1);
        set_now(23, 58); cyc(2);
        chk("t3_fire", pending, 4'b0001);
        pulse_snz();
`ifdef ALARM_SNOOZE_EN
        chk("t3_snz_clear", ring, 0);
        set_now(23, 59); cyc(3);
        chk("t3_quiet_a", ring, 0);
        set_now(0, 2); cyc(3);
        chk("t3_quiet_b", ring, 0);
        set_now(0, 3); cyc(2);
        chk("t3_refire", pending, 4'b0001);
        pulse_ack();
        chk("t3_ack", ring, 0);
        set_now(23, 57); cyc(3);
        set_now(23, 58); cyc(2);
        chk("t3_next_day", pending, 4'b0001);
        pulse_ack();
`else
        chk("t3_snz_ignored", ring, 1);
        chk("t3_snz_pend", pending, 4'b0001);
        pulse_ack();
        chk("t3_ack", ring, 0);
`endif

        // Unacknowledged ring auto-clears after RING_CYC cycles.
        set_now(9, 59); wr(3, 10, 0, 1); cyc(1);
        set_now(10, 0); cyc(2);
        chk("t4_fire_idx", ring_idx, 3);
        cyc(9);
        chk("t4_ring_last", ring, 1);
        chk("t4_to_early", timeout, 0);
        cyc(1);
        chk("t4_timeout", timeout, 1);
        chk("t4_ring_off", ring, 0);
        cyc(1);
        chk("t4_to_pulse", timeout, 0);

        // Out-of-range write leaves slot 3 armed at 10:00.
        wr(3, 24, 5, 0);
        set_now(9, 59); cyc(2);
        set_now(10, 0); cyc(2);
        chk("t5_invalid_ignored", pending, 4'b1000);
        // Turning a fired slot off drops its pending bit next cycle.
        wr(3, 10, 0, 0);
        chk("t6_off_clears", pending, 0);
        set_now(9, 59); cyc(2);
        set_now(10, 0); cyc(3);
        chk("t6_stays_off", pending, 0);

        // Asynchronous reset mid-ring.
        set_now(11, 59); cyc(2);
        set_now(12, 0); cyc(2);
        chk("t7_ringing", pending, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_ring", ring, 0);
        chk("t7_rst_pending", pending, 0);
        chk("t7_rst_idx", ring_idx, 0);
        chk("t7_rst_timeout", timeout, 0);
        cyc(2);
        rst_n = 1'b1;

        // Writing the current time fires two cycles after the write lands.
        wr(1, 12, 0, 1);
        cyc(1);
        chk("t8_not_yet", ring, 0);
        cyc(1);
        chk("t8_fire", pending, 4'b0010);
        pulse_ack();

        // Randomized traffic over a narrow time window so matches are frequent.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(3) == 0) set_now(6 + $urandom_range(1), $urandom_range(9));
            wr_en     = ($urandom_range(15) == 0);
            wr_idx    = IW'($urandom_range(NCH - 1));
            wr_H      = ($urandom_range(7) == 0) ? 5'(24 + $urandom_range(7))
                                                 : 5'(6 + $urandom_range(1));
            wr_M      = ($urandom_range(7) == 0) ? 6'(60 + $urandom_range(3))
                                                 : 6'($urandom_range(9));
            wr_enable = ($urandom_range(3) != 0);
            ack       = ($urandom_range(7) == 0);
            snooze    = ($urandom_range(5) == 0);
            cyc(1);
        end
        wr_en = 1'b0; ack = 1'b0; snooze = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
